// File: rtl/adder_pkg.sv
// adder_pkg: types and helpers shared by the serial adder and its digit slice.
//   adder_state_t : controller states (IDLE, RUN, DONE)
//   ovf_calc      : signed overflow from the carries around the MSB cell
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    // Two's-complement overflow occurs when the carry into the sign bit
    // differs from the carry out of it.
    function automatic logic ovf_calc(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage

// File: rtl/adder_digit.sv
// adder_digit: combinational DIGIT-bit ripple chain of full_adder cells.
//   a, b     : DIGIT-bit operand digits
//   cin      : carry into bit 0
//   sum      : DIGIT-bit result digit
//   cout     : carry out of the top cell
//   c_msb_in : carry into the top cell (needed for signed overflow)
module adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout     = w_c[DIGIT];
    assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   a, b, cin -> sum, cout
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor, DIGIT bits per clock.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, carry, ovf, zr, ng)
//   sub=0 -> a+b+cin ; sub=1 -> a-b-cin (carry=1 means no borrow)
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one digit per clock through the adder chain
//   DONE  | result and flags held, out_valid=1 until out_ready
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             zr,
    output logic             ng
);

    localparam int CYCLES = WIDTH / DIGIT;
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    adder_state_t     r_state;
    adder_state_t     w_next_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zr;
    logic             r_ng;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_sum_dig;
    logic             w_cout;
    logic             w_c_msb_in;
    logic [WIDTH-1:0] w_sum_next;

    assign w_accept = in_valid && w_in_ready;
    assign w_last   = (r_count == CW'(CYCLES - 1));

    // Digit select with constant part-selects, one per possible count value.
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int i = 0; i < CYCLES; i++) begin
            if (r_count == CW'(i)) begin
                w_a_dig = r_a[i*DIGIT +: DIGIT];
                w_b_dig = r_b[i*DIGIT +: DIGIT];
            end
        end
    end

    adder_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a        (w_a_dig),
        .b        (w_b_dig),
        .cin      (r_carry),
        .sum      (w_sum_dig),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    // Kept separate from the select block so the chain is not a false loop.
    always_comb begin
        w_sum_next = r_sum;
        for (int i = 0; i < CYCLES; i++) begin
            if (r_count == CW'(i)) begin
                w_sum_next[i*DIGIT +: DIGIT] = w_sum_dig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next_state = RUN;
            end
            RUN: begin
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zr    <= 1'b0;
            r_ng    <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1; a borrow-in removes the +1.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_count <= '0;
            r_sum   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= w_sum_next;
            r_carry <= w_cout;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= ovf_calc(w_c_msb_in, w_cout);
                r_zr   <= (w_sum_next == '0);
                r_ng   <= w_sum_next[WIDTH-1];
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign sum       = r_sum;
    assign carry     = r_cout;
    assign ovf       = r_ovf;
    assign zr        = r_zr;
    assign ng        = r_ng;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor; the sequential successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through a chain of full-adder cells, carrying between cycles in a register.
- Exposes Hack-ALU-style status flags.
- Sits in the arithmetic datapath as an area-lean alternative to a full-width ripple adder, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT != 0 is an elaboration-time $error.
- CYCLES, WIDTH/DIGIT, derived localparam: number of RUN cycles.

Ports:
- clk  input  1  sole clock; rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = a+b+cin; 1 = a-b-cin.
- out_valid  output  1  result held stable.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- carry  output  1  carry out of MSB. For sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- zr  output  1  sum == 0.
- ng  output  1  sum[WIDTH-1].

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: with rst_n low at a rising edge, state=IDLE and digit counter=0. Also in_ready=1 after reset; out_valid, sum, carry, ovf, zr, ng=0.
- Reset mid-RUN or in DONE: in-flight operation is discarded and no result is emitted.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE->RUN on in_valid&&in_ready. That edge latches:
  - a
  - b_eff = sub ? ~b : b
  - carry register = cin ^ sub
  - count = 0
  - sum shift register cleared
- RUN, each edge:
  - Digit index count is added via the DIGIT-bit full-adder chain with the carry register.
  - Result digit is written into sum bits [count*DIGIT +: DIGIT].
  - Carry register takes the chain carry-out; count increments.
  - At the final digit (count==CYCLES-1), the flags are captured and the state goes to DONE:
    - carry = final chain carry
    - ovf = carry into MSB ^ carry out of MSB
    - zr and ng are computed from the complete sum
- Latency: out_valid rises exactly CYCLES edges after the accepting edge. DIGIT==WIDTH gives 1 cycle.
- DONE->IDLE on out_valid&&out_ready.
  - sum and flags hold their values until the next accept.
  - out_valid may not drop without out_ready.
- in_valid while not IDLE is ignored; operands are not sampled.
- Changes to a, b, cin or sub after acceptance have no effect; operands are registered.
- Throughput: one result per CYCLES+2 cycles minimum. New operands are not accepted on the DONE handshake edge.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} adder_state_t
  - function ovf_calc
- Sub-module adder_digit:
  - parameter DIGIT
  - purely combinational chain of DIGIT full_adder instances
  - ports a, b, cin -> sum[DIGIT], cout, c_msb_in (carry into the top cell, used for ovf)
- Top-level serial_adder holds the FSM, counter, operand shift/select and result register.

Test Plan (WIDTH=16 unless stated):
- DIGIT=1, a=0x0001, b=0xFFFF, cin=0, sub=0 -> out_valid exactly 16 edges after accept; sum=0x0000, carry=1, ovf=0, zr=1, ng=0.
- DIGIT=4, a=0x7FFF, b=0x0001, sub=0 -> latency 4; sum=0x8000, carry=0, ovf=1, ng=1, zr=0.
- DIGIT=16, a=0x0005, b=0x0007, sub=1, cin=0 -> latency 1; sum=0xFFFE, carry=0, ng=1. Repeat with cin=1 -> sum=0xFFFD.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum and flags stable, in_ready=0 and a new in_valid is ignored. Release -> one handshake, then in_ready=1 next cycle.
- Reset mid-RUN: drive rst_n=0 at digit 7 of 16 -> next edge state IDLE, out_valid=0, sum=0, in_ready=1. A new op 0x1234+0x1111 then yields 0x2345.
- Randomised sweep (DIGIT in {1,2,4,8,16}, 500 ops each) against a behavioural a±b±cin model -> all of sum, carry, ovf, zr, ng match, with latency = CYCLES.
